crc_frame_ctrl: RTL and testbench

Frame sequencer for the parallel CRC-8 path (generator, error injector, checker). It accepts one frame of payload bytes from a source over a valid/ready handshake and buffers it. It drives the generator's data and enable and the checker's enable with the fixed inter-stage skew, then samples the checker's verdict. On a failed check it can replay the buffered frame.

---
 rtl/crc_frame_ctrl.sv | 162 ++++++++++++++++
 tb/tb_crc_frame_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for the parallel CRC-8 path: buffers one source frame, drives generator/checker enables.
// Define CRC_CTRL_RETRY_EN to build the frame buffer and replay-on-failure logic.
module crc_frame_ctrl #(
  parameter int MAX_LEN   = 8,
  parameter int PIPE_LAT  = 3,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] len,
  input  logic       src_valid,
  input  logic [7:0] src_data,
  output logic       src_ready,
  output logic       eng_clr,
  output logic [7:0] gen_data,
  output logic       gen_en,
  output logic       chk_en,
  input  logic       chk_valid,
  output logic       busy,
  output logic       done,
  output logic       frame_ok,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_dbg
);

  // Source handshake: a byte moves on a cycle where src_valid and src_ready are both high;
  // src_ready is a pure function of state and never waits on src_valid.
  typedef enum logic [2:0] {IDLE, CLR, FILL, FLUSH, CHECK, REPLAY, FIN} state_t;

`ifdef CRC_CTRL_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = MAX_RETRY * 0;
`endif

  localparam logic [3:0] MAX_LEN_W        = 4'(MAX_LEN);
  localparam logic [3:0] FLUSH_FIRST_LAST = 4'(PIPE_LAT - 1);
  localparam logic [3:0] FLUSH_RETRY_LAST = 4'(PIPE_LAT - 2);
  localparam logic [1:0] RETRY_LIMIT_W    = 2'(RETRY_LIMIT);

  state_t     state, state_next;
  logic [3:0] len_q, byte_cnt, flush_cnt;
  logic [1:0] retry_q;
  logic       accept, len_ok, last_byte, retrying, flush_last, can_retry;

  assign accept    = (state == FILL) && src_valid;
  assign len_ok    = (len != 4'd0) && (len <= MAX_LEN_W);
  assign last_byte = (byte_cnt == len_q - 4'd1);
  assign retrying  = (retry_q != 2'd0);
  assign can_retry = (retry_q < RETRY_LIMIT_W);
  // A replay keeps gen_en aligned with its state, so its flush is one cycle shorter.
  assign flush_last = retrying ? (flush_cnt == FLUSH_RETRY_LAST) : (flush_cnt == FLUSH_FIRST_LAST);

  assign src_ready = (state == FILL);
  assign eng_clr   = (state == CLR);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign retry_cnt = retry_q;
  assign state_dbg = state;

`ifdef CRC_CTRL_RETRY_EN
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic [7:0]    buf_mem [0:(1 << AW) - 1];
  logic [AW-1:0] rd_idx;
  logic [7:0]    buf_rd;

  assign rd_idx = (state == CLR) ? '0 : AW'(byte_cnt + 4'd1);
  assign buf_rd = buf_mem[rd_idx];

  always_ff @(posedge clk) begin
    if (accept) buf_mem[byte_cnt[AW-1:0]] <= src_data;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = len_ok ? CLR : FIN;
      CLR: begin
        state_next = FILL;
`ifdef CRC_CTRL_RETRY_EN
        if (retrying) state_next = REPLAY;
`endif
      end
      FILL:   if (accept && last_byte) state_next = FLUSH;
`ifdef CRC_CTRL_RETRY_EN
      REPLAY: if (last_byte) state_next = (PIPE_LAT == 1) ? CHECK : FLUSH;
`endif
      FLUSH:  if (flush_last) state_next = CHECK;
      CHECK:  state_next = (chk_valid || !can_retry) ? FIN : CLR;
      FIN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q     <= 4'd0;
      byte_cnt  <= 4'd0;
      flush_cnt <= 4'd0;
      retry_q   <= 2'd0;
      gen_data  <= 8'h00;
      gen_en    <= 1'b0;
      chk_en    <= 1'b0;
      frame_ok  <= 1'b0;
    end else begin
      gen_en <= 1'b0;
      // chk_en spans from the cycle after the first gen_en to the end of CHECK, gaps included.
      if (state == CHECK)  chk_en <= 1'b0;
      else if (gen_en)     chk_en <= 1'b1;
      case (state)
        IDLE: if (start) begin
          len_q    <= len;
          byte_cnt <= 4'd0;
          retry_q  <= 2'd0;
          frame_ok <= 1'b0;
        end
        CLR: begin
          byte_cnt  <= 4'd0;
          flush_cnt <= 4'd0;
`ifdef CRC_CTRL_RETRY_EN
          if (retrying) begin
            gen_data <= buf_rd;
            gen_en   <= 1'b1;
          end
`endif
        end
        FILL: begin
          flush_cnt <= 4'd0;
          if (accept) begin
            gen_data <= src_data;
            gen_en   <= 1'b1;
            byte_cnt <= last_byte ? 4'd0 : byte_cnt + 4'd1;
          end
        end
`ifdef CRC_CTRL_RETRY_EN
        REPLAY: begin
          if (last_byte) byte_cnt <= 4'd0;
          else begin
            gen_data <= buf_rd;
            gen_en   <= 1'b1;
            byte_cnt <= byte_cnt + 4'd1;
          end
        end
`endif
        FLUSH: flush_cnt <= flush_cnt + 4'd1;
        CHECK: begin
          if (chk_valid)      frame_ok <= 1'b1;
          else if (can_retry) retry_q  <= retry_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// Scoreboard bench for crc_frame_ctrl: a frame-level model pushes expected bytes and verdicts,
// a negedge monitor pops and compares whenever the DUT emits gen_en or done.
module tb_crc_frame_ctrl;
  localparam int MAX_LEN   = 8;
  localparam int PIPE_LAT  = 3;
  localparam int MAX_RETRY = 3;
`ifdef CRC_CTRL_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  logic       clk, reset, start, src_valid, chk_valid;
  logic [3:0] len;
  logic [7:0] src_data, gen_data;
  logic       src_ready, eng_clr, gen_en, chk_en, busy, done, frame_ok;
  logic [1:0] retry_cnt;
  logic [2:0] state_dbg;

  crc_frame_ctrl #(.MAX_LEN(MAX_LEN), .PIPE_LAT(PIPE_LAT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .eng_clr(eng_clr), .gen_data(gen_data), .gen_en(gen_en), .chk_en(chk_en),
    .chk_valid(chk_valid), .busy(busy), .done(done), .frame_ok(frame_ok),
    .retry_cnt(retry_cnt), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int   len;
    logic ok;
    int   retry;
    int   attempts;
    int   cycles;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] byte_arr[16];
  int         stall_arr[16];
  logic       verdicts[4];
  int         att_idx = 0;
  logic       last_ok = 1'b0;
  int         last_retry = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_src_ready"}, src_ready, 0);
    check({tag, "_eng_clr"}, eng_clr, 0);
    check({tag, "_gen_en"}, gen_en, 0);
    check({tag, "_chk_en"}, chk_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_frame_ok"}, frame_ok, 0);
    check({tag, "_gen_data"}, gen_data, 8'h00);
    check({tag, "_retry_cnt"}, retry_cnt, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // Checker stand-in: each eng_clr starts a new attempt whose verdict comes from verdicts[].
  initial begin
    chk_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_clr) begin
        chk_valid = verdicts[att_idx];
        if (att_idx < 3) att_idx++;
      end
    end
  end

  // Monitor: pops expected bytes on gen_en, expected frame results on done.
  initial begin
    int     busy_cyc, n_clr, gen_cnt, since_last, cur_len;
    bit     gen_seen, exp_chk;
    frame_t f;
    busy_cyc = 0; n_clr = 0; gen_cnt = 0; since_last = 0; gen_seen = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cyc = 0; n_clr = 0; gen_cnt = 0; since_last = 0; gen_seen = 0;
        last_ok = 1'b0; last_retry = 0;
        continue;
      end
      cur_len = (frame_q.size() != 0) ? frame_q[0].len : 0;
      if (busy) busy_cyc++;
      if (eng_clr) begin
        n_clr++; gen_seen = 0; gen_cnt = 0; since_last = 0;
      end
      if (gen_seen) since_last++;
      exp_chk = gen_seen && ((gen_cnt < cur_len) || (since_last <= PIPE_LAT));
      check("chk_en", chk_en, exp_chk);
      if (gen_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL gen_extra actual=%0h expected=none", gen_data);
        end else begin
          check("gen_data", gen_data, exp_q.pop_front());
        end
        gen_seen = 1; gen_cnt++; since_last = 0;
      end
      if (done) begin
        if (frame_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_extra actual=1 expected=0");
        end else begin
          f = frame_q.pop_front();
          check("frame_ok", frame_ok, f.ok);
          check("retry_cnt", retry_cnt, f.retry);
          check("attempts", n_clr, f.attempts);
          check("frame_cycles", busy_cyc, f.cycles);
          check("gen_missing", exp_q.size(), 0);
          exp_q.delete();
          last_ok = f.ok; last_retry = f.retry;
        end
        busy_cyc = 0; n_clr = 0; gen_seen = 0; gen_cnt = 0; since_last = 0;
      end else if (!busy) begin
        check("held_frame_ok", frame_ok, last_ok);
        check("held_retry_cnt", retry_cnt, last_retry);
      end
    end
  end

  // Issues one frame; abort_after>0 pulls reset low after that many bytes have been offered.
  task automatic run_frame(input int l, input bit poke_busy, input int abort_after);
    frame_t f;
    int     att, sum_st, cyc;
    bit     good;
    good = (l >= 1) && (l <= MAX_LEN);
    sum_st = 0;
    att = 0;
    if (good) begin
      for (int i = 0; i < l; i++) sum_st += stall_arr[i];
      while (!verdicts[att] && att < RETRIES) att++;
      f.ok = verdicts[att];
      f.retry = att;
      f.attempts = att + 1;
      f.cycles = l + 3 + PIPE_LAT + sum_st + att * (1 + l + PIPE_LAT);
      for (int a = 0; a <= att; a++)
        for (int i = 0; i < l; i++) exp_q.push_back(byte_arr[i]);
    end else begin
      f.ok = 1'b0; f.retry = 0; f.attempts = 0; f.cycles = 1;
    end
    f.len = l;
    frame_q.push_back(f);
    att_idx = 0;
    @(posedge clk); #1;
    start = 1'b1; len = 4'(l);
    @(posedge clk); #1;
    if (!good) begin
      len = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
    end else begin
      start = 1'b0;
      src_valid = 1'b1; src_data = 8'($urandom);
      @(posedge clk); #1;
      for (int i = 0; i < l; i++) begin
        for (int s = 0; s < stall_arr[i]; s++) begin
          src_valid = 1'b0; src_data = 8'($urandom);
          @(posedge clk); #1;
        end
        src_valid = 1'b1; src_data = byte_arr[i];
        @(posedge clk); #1;
        if (abort_after == i + 1) begin
          #1 reset = 1'b0;
          #1 check_reset_vals("abort");
          frame_q.delete(); exp_q.delete();
          src_valid = 1'b0;
          repeat (3) @(posedge clk);
          #1 reset = 1'b1;
          repeat (2) @(posedge clk);
          return;
        end
      end
      src_valid = 1'b1; src_data = 8'($urandom);
      if (poke_busy) begin
        start = 1'b1; len = 4'd2;
      end
      @(posedge clk); #1;
      src_valid = 1'b0; start = 1'b0;
    end
    cyc = 0;
    while (frame_q.size() != 0 && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    if (frame_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL frame_timeout actual=%0d expected=0 pending", frame_q.size());
      frame_q.delete(); exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_verdicts(input logic v0, input logic v1, input logic v2, input logic v3);
    verdicts[0] = v0; verdicts[1] = v1; verdicts[2] = v2; verdicts[3] = v3;
  endtask

  initial begin
    logic [7:0] clean [7];
    int         l;
    clean = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc, 8'hde};
    reset = 1'b0; start = 1'b0; len = 4'd0; src_valid = 1'b0; src_data = 8'h00;
    set_verdicts(1, 1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      stall_arr[i] = 0; byte_arr[i] = 8'h00;
    end
    #12 check_reset_vals("rst");
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) byte_arr[i] = clean[i];
    run_frame(7, 0, 0);
    set_verdicts(0, 1, 1, 1);
    run_frame(7, 0, 0);
    set_verdicts(0, 0, 0, 0);
    run_frame(7, 0, 0);

    set_verdicts(1, 1, 1, 1);
    byte_arr[0] = 8'ha1; byte_arr[1] = 8'hb2; byte_arr[2] = 8'hc3;
    stall_arr[1] = 2;
    run_frame(3, 0, 0);
    stall_arr[1] = 0; stall_arr[3] = 5;
    byte_arr[3] = 8'hd4;
    run_frame(4, 1, 0);
    stall_arr[3] = 0;

    run_frame(0, 0, 0);
    run_frame(9, 0, 0);
    run_frame(15, 0, 0);

    set_verdicts(0, 1, 1, 1);
    byte_arr[0] = 8'h5a;
    run_frame(1, 0, 0);
    set_verdicts(0, 0, 1, 1);
    for (int i = 0; i < MAX_LEN; i++) byte_arr[i] = 8'(8'h30 + i);
    run_frame(MAX_LEN, 0, 0);

    set_verdicts(1, 1, 1, 1);
    for (int i = 0; i < 5; i++) byte_arr[i] = 8'($urandom);
    run_frame(5, 0, 2);
    run_frame(5, 0, 0);

    for (int n = 0; n < 30; n++) begin
      l = $urandom_range(1, MAX_LEN);
      if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 15);
      for (int i = 0; i < 16; i++) begin
        byte_arr[i] = 8'($urandom);
        stall_arr[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      end
      for (int a = 0; a < 4; a++) verdicts[a] = 1'($urandom_range(0, 1));
      run_frame(l, 1'($urandom_range(0, 1)), 0);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
